// File: rtl/instruction_loader.sv
// Program loader: assembles a big-endian byte stream into 32-bit words, writes them
// to instruction memory and holds the CPU in reset until the load completes.
module instruction_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [8:0]  word_count,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        cpu_reset,
  output logic        busy,
  output logic        done
);

  localparam int unsigned CNT_W = 9;
  localparam int unsigned IDX_W = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic [1:0]       bcnt_q, bcnt_d;
  logic [23:0]      word_q, word_d;
  logic [CNT_W-1:0] clamped_c;
  logic             byte_ready_d;
  logic             mem_write_d;
  logic [31:0]      mem_addr_d;
  logic [31:0]      mem_write_data_d;
  logic             cpu_reset_d;
  logic             busy_d;
  logic             done_d;

  // State and registered outputs; reset discards any partial word.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      count_q        <= '0;
      index_q        <= '0;
      bcnt_q         <= '0;
      word_q         <= '0;
      byte_ready     <= 1'b0;
      mem_write      <= 1'b0;
      mem_addr       <= BASE_ADDR;
      mem_write_data <= '0;
      cpu_reset      <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      index_q        <= index_d;
      bcnt_q         <= bcnt_d;
      word_q         <= word_d;
      byte_ready     <= byte_ready_d;
      mem_write      <= mem_write_d;
      mem_addr       <= mem_addr_d;
      mem_write_data <= mem_write_data_d;
      cpu_reset      <= cpu_reset_d;
      busy           <= busy_d;
      done           <= done_d;
    end
  end

  // Next-state and datapath; outputs are decoded from the next state so they are registered.
  always_comb begin
    state_d          = state_q;
    count_d          = count_q;
    index_d          = index_q;
    bcnt_d           = bcnt_q;
    word_d           = word_q;
    mem_addr_d       = mem_addr;
    mem_write_data_d = mem_write_data;
    clamped_c        = (word_count > MAX_CNT) ? MAX_CNT : word_count;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          count_d = clamped_c;
          index_d = '0;
          bcnt_d  = '0;
          state_d = (clamped_c == '0) ? DONE : RECV;
        end
      end

      RECV: begin
        if (byte_valid && byte_ready) begin
          // Only the first three bytes are kept; the fourth goes straight into the write word.
          word_d = {word_q[15:0], byte_data};
          if (bcnt_q == 2'd3) begin
            bcnt_d           = '0;
            mem_write_data_d = {word_q, byte_data};
            mem_addr_d       = BASE_ADDR + (32'(index_q) << 2);
            state_d          = WRITE;
          end else begin
            bcnt_d = bcnt_q + 2'd1;
          end
        end
      end

      WRITE: begin
        // Index is left at the last word on completion so it never exceeds MAX_WORDS-1.
        if ((CNT_W'(index_q) + CNT_W'(1)) == count_q) begin
          state_d = DONE;
        end else begin
          index_d = index_q + IDX_W'(1);
          state_d = RECV;
        end
      end

      default: state_d = IDLE;
    endcase

    byte_ready_d = (state_d == RECV);
    mem_write_d  = (state_d == WRITE);
    busy_d       = (state_d == RECV) || (state_d == WRITE);
    done_d       = (state_d == DONE);
    cpu_reset_d  = (state_d == DONE);
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Bench for instruction_loader: directed scenarios plus random loads checked against
// a word-list model built from the transmitted byte stream.
module tb_instruction_loader;

  localparam logic [31:0] BASE = 32'h0000_2000;
  localparam int MAXW = 256;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [8:0]  word_count;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        cpu_reset;
  logic        busy;
  logic        done;

  instruction_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clock(clock), .reset(reset), .start(start), .word_count(word_count),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .cpu_reset(cpu_reset), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [7:0]  tx[$];
  logic [31:0] wq_addr[$];
  logic [31:0] wq_data[$];
  int          wq_cyc[$];
  int          last_acc_cyc = -100;
  int          done_rise_cyc = -1;
  int          viol = 0;
  logic        done_prev = 1'b0;

  // Observer: records writes and tracks cycle-level rules of the handshake.
  always @(negedge clock) begin
    #1;
    if (reset) begin
      if (mem_write) begin
        wq_addr.push_back(mem_addr);
        wq_data.push_back(mem_write_data);
        wq_cyc.push_back(cyc);
        if (cyc != last_acc_cyc + 1) viol++;
      end
      if (busy) begin
        if (byte_ready == mem_write) viol++;
        if (cpu_reset) viol++;
      end else if (byte_ready || mem_write) begin
        viol++;
      end
      if (done != cpu_reset) viol++;
      if (byte_valid && byte_ready) last_acc_cyc = cyc;
      if (done && !done_prev) done_rise_cyc = cyc;
    end
    done_prev = done;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_byte_ready"}, 64'(byte_ready), 64'(0));
    check({tag, "_mem_write"}, 64'(mem_write), 64'(0));
    check({tag, "_mem_addr"}, 64'(mem_addr), 64'(BASE));
    check({tag, "_mem_write_data"}, 64'(mem_write_data), 64'(0));
    check({tag, "_cpu_reset"}, 64'(cpu_reset), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
  endtask

  task automatic gen_tx(input int nbytes);
    tx.delete();
    for (int i = 0; i < nbytes; i++) tx.push_back(8'($urandom_range(255, 0)));
  endtask

  task automatic clear_obs();
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
    done_rise_cyc = -1;
  endtask

  task automatic do_start(input int wc);
    @(negedge clock);
    start = 1'b1;
    word_count = 9'(wc);
    @(negedge clock);
    start = 1'b0;
  endtask

  // Presents tx[first +: n]; a byte counts as taken when byte_ready is seen with it on the bus.
  task automatic drive(input int first, input int n, input int gmin, input int gmax);
    int i;
    int g;
    int budget;
    i = first;
    g = 0;
    budget = n * (gmax + 2) * 2 + 64;
    while (i < first + n && budget > 0) begin
      if (g > 0) begin
        byte_valid = 1'b0;
        g--;
      end else begin
        byte_valid = 1'b1;
        byte_data = tx[i];
        if (byte_ready) begin
          i++;
          g = int'($urandom_range(gmax, gmin));
        end
      end
      @(negedge clock);
      budget--;
    end
    byte_valid = 1'b0;
    check("drive_complete", 64'(i), 64'(first + n));
  endtask

  task automatic wait_done();
    int b;
    b = 0;
    while (!done && b < 40) begin
      @(negedge clock);
      b++;
    end
    check("wait_done", 64'(done), 64'(1));
    #2;
  endtask

  task automatic check_load(input string tag, input int wc, input bit gap_free);
    int n;
    logic [31:0] exp_d;
    n = (wc > MAXW) ? MAXW : wc;
    check({tag, "_nwrites"}, 64'(wq_addr.size()), 64'(n));
    for (int i = 0; i < n && i < wq_addr.size(); i++) begin
      exp_d = {tx[4*i], tx[4*i+1], tx[4*i+2], tx[4*i+3]};
      check({tag, "_addr"}, 64'(wq_addr[i]), 64'(BASE + 32'(4 * i)));
      check({tag, "_data"}, 64'(wq_data[i]), 64'(exp_d));
    end
    if (wq_cyc.size() > 0) begin
      check({tag, "_done_timing"}, 64'(done_rise_cyc), 64'(wq_cyc[wq_cyc.size()-1] + 1));
      check({tag, "_addr_hold"}, 64'(mem_addr), 64'(BASE + 32'(4 * (n - 1))));
    end
    if (gap_free) begin
      for (int i = 1; i < wq_cyc.size(); i++)
        check({tag, "_spacing"}, 64'(wq_cyc[i] - wq_cyc[i-1]), 64'(5));
    end
    check({tag, "_done"}, 64'(done), 64'(1));
    check({tag, "_cpu_reset"}, 64'(cpu_reset), 64'(1));
    check({tag, "_busy"}, 64'(busy), 64'(0));
  endtask

  initial begin
    int wc;
    reset = 1'b1;
    start = 1'b0;
    byte_valid = 1'b0;
    byte_data = 8'h00;
    word_count = 9'd0;
    #1 reset = 1'b0;
    #1 check_reset_vals("por");
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_reset_vals("idle");

    // Zero-length load goes straight to DONE.
    clear_obs();
    do_start(0);
    check("zero_done", 64'(done), 64'(1));
    check("zero_cpu_reset", 64'(cpu_reset), 64'(1));
    check("zero_busy", 64'(busy), 64'(0));
    repeat (3) @(negedge clock);
    check("zero_nwrites", 64'(wq_addr.size()), 64'(0));

    // Directed two-word load, restarted from DONE.
    tx = '{8'h8C, 8'h08, 8'h00, 8'h04, 8'h01, 8'h09, 8'h50, 8'h20};
    clear_obs();
    do_start(2);
    check("restart_done", 64'(done), 64'(0));
    check("restart_cpu_reset", 64'(cpu_reset), 64'(0));
    check("restart_busy", 64'(busy), 64'(1));
    drive(0, 8, 0, 0);
    wait_done();
    check_load("directed", 2, 1'b1);
    if (wq_data.size() == 2) begin
      check("directed_word0", 64'(wq_data[0]), 64'(32'h8C08_0004));
      check("directed_word1", 64'(wq_data[1]), 64'(32'h0109_5020));
    end

    // Same stream with three idle cycles between bytes.
    clear_obs();
    do_start(2);
    drive(0, 8, 3, 3);
    wait_done();
    check_load("gap3", 2, 1'b0);

    // Random loads with random gaps.
    for (int k = 0; k < 4; k++) begin
      wc = int'($urandom_range(6, 1));
      gen_tx(4 * wc);
      clear_obs();
      do_start(wc);
      drive(0, 4 * wc, 0, 3);
      wait_done();
      check_load("rand", wc, 1'b0);
    end

    // start while busy is ignored; count stays at 2.
    gen_tx(8);
    clear_obs();
    do_start(2);
    drive(0, 3, 0, 0);
    start = 1'b1;
    word_count = 9'd1;
    @(negedge clock);
    start = 1'b0;
    check("busy_start_busy", 64'(busy), 64'(1));
    drive(3, 5, 0, 0);
    wait_done();
    check_load("busy_start", 2, 1'b0);

    // Reset in the middle of the first word.
    gen_tx(8);
    clear_obs();
    do_start(2);
    drive(0, 2, 0, 0);
    reset = 1'b0;
    #1 check_reset_vals("midreset");
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (4) @(negedge clock);
    check("midreset_nwrites", 64'(wq_addr.size()), 64'(0));
    check_reset_vals("midreset_idle");
    gen_tx(4);
    clear_obs();
    do_start(1);
    drive(0, 4, 0, 0);
    wait_done();
    check_load("after_reset", 1, 1'b1);

    // Oversized count clamps to MAX_WORDS.
    gen_tx(4 * MAXW);
    clear_obs();
    do_start(300);
    drive(0, 4 * MAXW, 0, 0);
    wait_done();
    check_load("clamp", 300, 1'b1);
    if (wq_addr.size() > 0)
      check("clamp_last_addr", 64'(wq_addr[wq_addr.size()-1]), 64'(BASE + 32'h3FC));

    // Bytes presented in DONE are ignored.
    byte_valid = 1'b1;
    byte_data = 8'hAA;
    repeat (6) @(negedge clock);
    check("done_ignore_ready", 64'(byte_ready), 64'(0));
    byte_valid = 1'b0;
    repeat (2) @(negedge clock);
    check("done_ignore_nwrites", 64'(wq_addr.size()), 64'(MAXW));
    check("done_ignore_done", 64'(done), 64'(1));

    check("cycle_rules", 64'(viol), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_loader.md
INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 The block SHALL have parameter: BASE_ADDR, 32'h0000_0000, byte address of the first instruction word written.
REQ-002 The block SHALL have parameter: MAX_WORDS, 256, capacity of instruction memory in words; upper bound on word_count.
REQ-003 The block SHALL have port: clock  input  1  single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port: reset  input  1  asynchronous, active-low; reset == 0 forces the reset state immediately.
REQ-005 The block SHALL have port: start  input  1  one-cycle request to begin a program load.
REQ-006 The block SHALL have port: word_count  input  9  number of 32-bit words to load, sampled at start.
REQ-007 The block SHALL have port: byte_valid  input  1  program byte present on byte_data.
REQ-008 The block SHALL have port: byte_data  input  8  program byte stream, most significant byte of each word first.
REQ-009 The block SHALL have port: byte_ready  output  1  loader accepts byte_data this cycle.
REQ-010 The block SHALL have port: mem_write  output  1  one-cycle write strobe to instruction memory.
REQ-011 The block SHALL have port: mem_addr  output  32  word-aligned byte address of the write.
REQ-012 The block SHALL have port: mem_write_data  output  32  assembled instruction word.
REQ-013 The block SHALL have port: cpu_reset  output  1  active-low reset driven to the CPU; 0 holds the CPU in reset.
REQ-014 The block SHALL have port: busy  output  1  load in progress.
REQ-015 The block SHALL have port: done  output  1  last load completed; CPU released.

Function
REQ-016 The FSM SHALL have states IDLE, RECV, WRITE, DONE.
REQ-017 IDLE: cpu_reset = 0; on start, latch word_count (values > MAX_WORDS clamp to MAX_WORDS), clear word index and byte counter, go to RECV; if the latched count is 0, go directly to DONE.
REQ-018 RECV: byte_ready = 1; a byte is accepted when byte_valid && byte_ready on a rising edge; byte k (0..3) of a word SHALL be placed in bits [31-8k:24-8k].
REQ-019 On acceptance of byte 3, the FSM SHALL enter WRITE on the same edge.
REQ-020 WRITE: for exactly one cycle, mem_write = 1, mem_write_data = the assembled word, mem_addr = BASE_ADDR + 4*index; byte_ready = 0.
REQ-021 After WRITE, index SHALL increment; if the new index equals the latched count, go to DONE; otherwise go to RECV.
REQ-022 Throughput SHALL be one byte per cycle in RECV, giving 5 cycles per word with continuous byte_valid.
REQ-023 mem_write SHALL assert on the cycle immediately following acceptance of the 4th byte.
REQ-024 DONE: cpu_reset = 1, done = 1, busy = 0, byte_ready = 0; bytes presented SHALL be ignored.
REQ-025 busy SHALL be 1 in RECV and WRITE and 0 otherwise; cpu_reset SHALL be 0 whenever busy = 1.
REQ-026 start SHALL be ignored while busy = 1.
REQ-027 start in DONE SHALL restart a load: done -> 0 and cpu_reset -> 0 on the next cycle, with the same actions as REQ-017.
REQ-028 byte_valid deasserted mid-word SHALL stall without loss; the byte counter and partial word SHALL be held.
REQ-029 mem_addr SHALL hold its last value outside WRITE; the index SHALL never exceed MAX_WORDS-1.

Reset
REQ-030 On reset == 0, the block SHALL immediately (asynchronously) enter IDLE with byte_ready = 0, mem_write = 0, mem_addr = BASE_ADDR, mem_write_data = 0, cpu_reset = 0, busy = 0, done = 0, and index, byte counter, and latched count = 0.
REQ-031 Reset asserted mid-load SHALL discard the partial word with no write; after reset deasserts, the block SHALL wait in IDLE for a new start.

Verification
REQ-032 Scenario: start with word_count=2, continuous bytes 8C,08,00,04,01,09,50,20 -> mem_write pulses carry 32'h8C080004 @0x0 and 32'h01095020 @0x4, 5 cycles apart; done and cpu_reset rise together one cycle after the second write.
REQ-033 Scenario: start with word_count=0 -> DONE next cycle; no mem_write; cpu_reset = 1.
REQ-034 Scenario: byte_valid gaps of 3 cycles between bytes -> same words and addresses as REQ-032; byte_ready = 0 only in WRITE.
REQ-035 Scenario: reset pulsed low after 2 bytes of word 1 -> no write, all outputs at reset values immediately; a new start reloads from BASE_ADDR.
REQ-036 Scenario: start while busy, and a later start from DONE -> the first start is ignored; the second drives cpu_reset to 0 and rewrites from BASE_ADDR.
REQ-037 Scenario: word_count=300 with MAX_WORDS=256 -> exactly 256 writes, last at 0x3FC; then DONE.
